// File: rtl/cpu_types_pkg.sv
// Shared types for the datapath/cache/RAM interface.
package cpu_types_pkg;

    // Machine word used on every datapath and RAM data/address bus
    typedef logic [31:0] word_t;

    // Handshake state reported by the RAM for the current access
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port memory responder: serialises data and instruction requests
// onto one RAM port (data first), returns registered one-cycle hit pulses,
// quiesces on halt and traps RAM errors and timeouts.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr,
    output logic        halted
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Counter value at which the wait saturates and the access is abandoned
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
    // Last counter value before reaching TIMEOUT on the next non-ACCESS cycle
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        DACC,
        IACC,
        HALTED,
        ERR
    } arb_state_t;

    arb_state_t       r_state;
    arb_state_t       w_next;

    word_t            r_addr;
    word_t            r_store;
    logic             r_wr;
    logic [CNT_W-1:0] r_wait;
    logic             r_halt_pend;
    logic             r_ihit;
    logic             r_dhit;
    word_t            r_iload;
    word_t            r_dload;

    logic             w_in_acc;
    logic             w_access;
    logic             w_fail;
    logic             w_hit_cycle;
    logic             w_start_d;
    logic             w_start_i;

    assign w_in_acc    = (r_state == DACC) || (r_state == IACC);
    assign w_access    = (ramstate == ACCESS);
    // The counter would reach TIMEOUT at this edge, or the RAM flagged a fault
    assign w_fail      = (ramstate == ERROR) || (r_wait >= LAST_WAIT);
    // During a hit pulse the datapath has not yet reacted, so its request is stale
    assign w_hit_cycle = r_ihit | r_dhit;
    assign w_start_d   = (r_state == IDLE) && (w_next == DACC);
    assign w_start_i   = (r_state == IDLE) && (w_next == IACC);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection: data has priority over fetch, halt over both
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (halt) begin
                    w_next = HALTED;
                end else if (!w_hit_cycle && (dmemREN || dmemWEN)) begin
                    w_next = DACC;
                end else if (!w_hit_cycle && imemREN) begin
                    w_next = IACC;
                end
            end
            DACC, IACC: begin
                if (w_access) begin
                    w_next = (halt || r_halt_pend) ? HALTED : IDLE;
                end else if (w_fail) begin
                    w_next = ERR;
                end
            end
            HALTED:  w_next = HALTED;
            ERR:     w_next = ERR;
            default: w_next = IDLE;
        endcase
    end

    // RAM-side drive and status flags decoded from the current state
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        memerr   = (r_state == ERR);
        halted   = (r_state == HALTED);
        if (w_in_acc) begin
            ramREN  = !r_wr;
            ramWEN  = r_wr;
            ramaddr = r_addr;
            if (r_wr) begin
                ramstore = r_store;
            end
        end
    end

    // Capture the accepted request so the RAM side stays stable mid-access
    always_ff @(posedge CLK) begin
        if (w_start_d) begin
            r_addr  <= dmemaddr;
            r_store <= dmemstore;
        end else if (w_start_i) begin
            r_addr  <= imemaddr;
            r_store <= '0;
        end
    end

    // Write flag for the in-flight access; a write wins over a read
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr <= 1'b0;
        end else if (w_start_d) begin
            r_wr <= dmemWEN;
        end else if (w_start_i) begin
            r_wr <= 1'b0;
        end
    end

    // Saturating wait counter, cleared on entry to an access
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wait <= '0;
        end else if (w_start_d || w_start_i) begin
            r_wait <= '0;
        end else if (w_in_acc && !w_access && (r_wait != CNT_MAX)) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    // Remember a halt seen during an access so it is honoured at completion
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_halt_pend <= 1'b0;
        end else if (r_state == IDLE) begin
            r_halt_pend <= 1'b0;
        end else if (w_in_acc && halt) begin
            r_halt_pend <= 1'b1;
        end
    end

    // One-cycle hit pulses on completion of the matching access
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ihit <= 1'b0;
            r_dhit <= 1'b0;
        end else begin
            r_ihit <= (r_state == IACC) && w_access;
            r_dhit <= (r_state == DACC) && w_access;
        end
    end

    // Load data registers; they hold their value between hits
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_iload <= '0;
            r_dload <= '0;
        end else begin
            if ((r_state == IACC) && w_access) begin
                r_iload <= ramload;
            end
            if ((r_state == DACC) && w_access && !r_wr) begin
                r_dload <= ramload;
            end
        end
    end

    assign ihit     = r_ihit;
    assign dhit     = r_dhit;
    assign imemload = r_iload;
    assign dmemload = r_dload;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed plus randomised bench for memory_arbiter with a behavioural RAM.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int TO = 4;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        ihit;
    logic [31:0] imemload;
    logic        dhit;
    logic [31:0] dmemload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        memerr;
    logic        halted;

    memory_arbiter #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .halt(halt),
        .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .memerr(memerr), .halted(halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference RAM contents and expected load registers
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_iload;
    logic [31:0] exp_dload;

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, ".ramREN"}, ramREN, 1'b0);
        chk1({tag, ".ramWEN"}, ramWEN, 1'b0);
        chk32({tag, ".ramaddr"}, ramaddr, 32'h0);
        chk32({tag, ".ramstore"}, ramstore, 32'h0);
        chk1({tag, ".ihit"}, ihit, 1'b0);
        chk1({tag, ".dhit"}, dhit, 1'b0);
        chk32({tag, ".imemload"}, imemload, 32'h0);
        chk32({tag, ".dmemload"}, dmemload, 32'h0);
        chk1({tag, ".memerr"}, memerr, 1'b0);
        chk1({tag, ".halted"}, halted, 1'b0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
        ramstate = FREE;
        tick();
        RST = 1'b0;
        exp_iload = 32'h0;
        exp_dload = 32'h0;
    endtask

    // One access from an idle arbiter: request in cycle 0, nbusy wait cycles,
    // ACCESS in cycle 1+nbusy, hit in cycle 2+nbusy.
    task automatic access(input logic is_d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int nbusy, input logic do_halt);
        if (is_d) begin
            dmemREN = !wr; dmemWEN = wr; dmemaddr = addr; dmemstore = wdata;
        end else begin
            imemREN = 1'b1; imemaddr = addr;
        end
        ramstate = FREE;
        tick();
        // Scramble datapath inputs: the RAM side must not follow them
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        imemaddr = $urandom; dmemaddr = $urandom; dmemstore = $urandom;
        if (do_halt) halt = 1'b1;
        for (int i = 0; i <= nbusy; i++) begin
            chk1("acc.ramREN", ramREN, !wr);
            chk1("acc.ramWEN", ramWEN, wr);
            chk32("acc.ramaddr", ramaddr, addr);
            if (wr) chk32("acc.ramstore", ramstore, wdata);
            chk1("acc.ihit_wait", ihit, 1'b0);
            chk1("acc.dhit_wait", dhit, 1'b0);
            chk1("acc.memerr", memerr, 1'b0);
            if (i < nbusy) begin
                ramstate = (i % 2 == 0) ? BUSY : FREE;
                ramload  = $urandom;
            end else begin
                ramstate = ACCESS;
                if (wr) begin
                    mem[addr] = wdata;
                    ramload   = $urandom;
                end else begin
                    ramload = memrd(addr);
                end
            end
            tick();
        end
        ramstate = FREE;
        if (is_d && !wr) exp_dload = memrd(addr);
        if (!is_d) exp_iload = memrd(addr);
        chk1("hit.dhit", dhit, is_d);
        chk1("hit.ihit", ihit, !is_d);
        chk32("hit.imemload", imemload, exp_iload);
        if (is_d && !wr) chk32("hit.dmemload", dmemload, exp_dload);
        chk1("hit.ramREN", ramREN, 1'b0);
        chk1("hit.ramWEN", ramWEN, 1'b0);
        chk1("hit.halted", halted, do_halt);
        tick();
        chk1("post.ihit", ihit, 1'b0);
        chk1("post.dhit", dhit, 1'b0);
    endtask

    initial begin
        RST = 1'b1;
        imemREN = 1'b0; imemaddr = '0;
        dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
        halt = 1'b0; ramload = '0; ramstate = FREE;
        exp_iload = '0; exp_dload = '0;
        mem[32'h40] = 32'h8C22_0004;
        tick();
        tick();
        RST = 1'b0;
        chk_all_zero("reset");

        // Fetch 0x40 with immediate ACCESS: ihit in cycle 2
        access(1'b0, 1'b0, 32'h40, 32'h0, 0, 1'b0);
        chk32("fetch40.imemload", imemload, 32'h8C22_0004);
        // Data read with one wait cycle
        access(1'b1, 1'b0, 32'h44, 32'h0, 1, 1'b0);

        // Simultaneous fetch and write: write first, dhit cycle 4, ihit cycle 9
        imemREN = 1'b1; imemaddr = 32'h0;
        dmemWEN = 1'b1; dmemaddr = 32'h100; dmemstore = 32'hDEAD_BEEF;
        ramstate = FREE;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 5) dmemWEN = 1'b0;
            if (c == 9) imemREN = 1'b0;
            chk1($sformatf("both.c%0d.ramWEN", c), ramWEN, (c >= 1 && c <= 3));
            chk1($sformatf("both.c%0d.ramREN", c), ramREN, (c >= 6 && c <= 8));
            chk32($sformatf("both.c%0d.ramaddr", c), ramaddr, (c >= 1 && c <= 3) ? 32'h100 : 32'h0);
            if (c >= 1 && c <= 3) chk32("both.ramstore", ramstore, 32'hDEAD_BEEF);
            chk1($sformatf("both.c%0d.dhit", c), dhit, (c == 4));
            chk1($sformatf("both.c%0d.ihit", c), ihit, (c == 9));
            if (c == 3) mem[32'h100] = 32'hDEAD_BEEF;
            if (c == 9) begin
                exp_iload = memrd(32'h0);
                chk32("both.imemload", imemload, exp_iload);
            end
            ramstate = (c == 3 || c == 8) ? ACCESS :
                       (c == 1 || c == 2 || c == 6 || c == 7) ? BUSY : FREE;
            ramload  = (c == 8) ? memrd(32'h0) : $urandom;
        end

        // Randomised mix of fetches, reads and writes over a small address window
        for (int n = 0; n < 24; n++) begin
            logic        r_is_d;
            logic        r_wr;
            logic [31:0] r_addr;
            r_is_d = 1'($urandom_range(0, 1));
            r_wr   = r_is_d & 1'($urandom_range(0, 1));
            r_addr = $urandom_range(0, 15) << 2;
            access(r_is_d, r_wr, r_addr, $urandom, int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset on the second BUSY cycle of a fetch
        imemREN = 1'b1; imemaddr = 32'h80; ramstate = FREE;
        tick();
        ramstate = BUSY;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; imemREN = 1'b0; ramstate = FREE;
        exp_iload = 32'h0; exp_dload = 32'h0;
        chk_all_zero("midrst");
        access(1'b0, 1'b0, 32'h80, 32'h0, 2, 1'b0);

        // RAM ERROR during a fetch: sticky error, no hit, imemload unchanged
        imemREN = 1'b1; imemaddr = 32'h8; ramstate = FREE;
        tick();
        imemREN = 1'b0; ramstate = BUSY;
        tick();
        ramstate = ERROR;
        tick();
        ramstate = FREE; imemREN = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk1("err.memerr", memerr, 1'b1);
            chk1("err.ihit", ihit, 1'b0);
            chk1("err.ramREN", ramREN, 1'b0);
            chk32("err.imemload", imemload, exp_iload);
            tick();
        end

        // Timeout: RAM stays BUSY, error after TO wait cycles
        do_reset();
        dmemREN = 1'b1; dmemaddr = 32'h200; ramstate = FREE;
        tick();
        dmemREN = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            chk1($sformatf("to.c%0d.memerr", c), memerr, 1'b0);
            chk1($sformatf("to.c%0d.ramREN", c), ramREN, 1'b1);
            ramstate = BUSY;
            tick();
        end
        ramstate = ACCESS; dmemREN = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk1("to.memerr", memerr, 1'b1);
            chk1("to.dhit", dhit, 1'b0);
            chk1("to.ramREN", ramREN, 1'b0);
            tick();
        end

        // Halt raised mid data read: hit delivered, then quiesced
        do_reset();
        access(1'b1, 1'b0, 32'h24, 32'h0, 2, 1'b1);
        dmemREN = 1'b1; imemREN = 1'b1; dmemaddr = 32'h4; ramstate = ACCESS;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk1("halt.halted", halted, 1'b1);
            chk1("halt.ramREN", ramREN, 1'b0);
            chk1("halt.ramWEN", ramWEN, 1'b0);
            chk1("halt.dhit", dhit, 1'b0);
            chk1("halt.ihit", ihit, 1'b0);
        end

        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
